fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer.sv | 135 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks every stage and butterfly pair,
// issues sample RAM reads with twiddle indices, and replays them one cycle later as writes.
module fft_stage_sequencer #(
    parameter int LOG2N = 3,
    localparam int STAGE_W = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1,
    localparam int TW_W = LOG2N - 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_rd_en,
    output logic [LOG2N-1:0]   o_rd_addr_a,
    output logic [LOG2N-1:0]   o_rd_addr_b,
    output logic [TW_W-1:0]    o_tw_addr,
    output logic               o_wr_en,
    output logic [LOG2N-1:0]   o_wr_addr_a,
    output logic [LOG2N-1:0]   o_wr_addr_b,
    output logic [STAGE_W-1:0] o_stage
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [TW_W-1:0]    J_LAST     = '1;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

    state_t             state;
    logic [TW_W-1:0]    j;
    logic [STAGE_W-1:0] stage;
    logic               rd_en_p0;
    logic               busy;
    logic               done;

    logic [LOG2N-1:0]   j_ext;
    logic [LOG2N-1:0]   span;
    logic [LOG2N-1:0]   pos;
    logic [LOG2N-1:0]   grp;
    logic [LOG2N-1:0]   addr_a_p0;
    logic [LOG2N-1:0]   addr_b_p0;
    logic [TW_W-1:0]    tw_p0;

    logic               wr_en_p1;
    logic [LOG2N-1:0]   wr_addr_a_p1;
    logic [LOG2N-1:0]   wr_addr_b_p1;

    // Stage p0: butterfly pair addresses derived from the (stage, j) counters
    always_comb begin
        j_ext     = {1'b0, j};
        span      = LOG2N'(1) << stage;
        pos       = j_ext & (span - LOG2N'(1));
        grp       = j_ext >> stage;
        addr_a_p0 = ((grp << stage) << 1) | pos;
        addr_b_p0 = addr_a_p0 + span;
        tw_p0     = TW_W'(pos << (STAGE_LAST - stage));
    end

    // Addresses are forced to zero whenever no read is issued, so idle/drain/reset show all zeros
    assign o_rd_en     = rd_en_p0;
    assign o_rd_addr_a = rd_en_p0 ? addr_a_p0 : '0;
    assign o_rd_addr_b = rd_en_p0 ? addr_b_p0 : '0;
    assign o_tw_addr   = rd_en_p0 ? tw_p0 : '0;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_stage     = stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            j        <= '0;
            stage    <= '0;
            rd_en_p0 <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= READ;
                        j        <= '0;
                        stage    <= '0;
                        rd_en_p0 <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                READ: begin
                    if (j == J_LAST) begin
                        state    <= DRAIN;
                        rd_en_p0 <= 1'b0;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                // One idle read slot lets the last write of a stage land before the next stage reads
                DRAIN: begin
                    if (stage == STAGE_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= READ;
                        stage    <= stage + 1'b1;
                        j        <= '0;
                        rd_en_p0 <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= '0;
                    j     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: write strobe and addresses trail the read by the RAM read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_en_p1     <= 1'b0;
            wr_addr_a_p1 <= '0;
            wr_addr_b_p1 <= '0;
        end else begin
            wr_en_p1     <= rd_en_p0;
            wr_addr_a_p1 <= o_rd_addr_a;
            wr_addr_b_p1 <= o_rd_addr_b;
        end
    end

    assign o_wr_en     = wr_en_p1;
    assign o_wr_addr_a = wr_addr_a_p1;
    assign o_wr_addr_b = wr_addr_b_p1;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: N=8 schedule tables, start/reset robustness,
// an N=16 completion run, and an impulse FFT through a RAM plus butterfly model.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       start16 = 1'b0;
    logic       load = 1'b0;

    logic       busy, done, rd_en, wr_en;
    logic [2:0] rd_a, rd_b, wr_a, wr_b;
    logic [1:0] tw;
    logic [1:0] stage;

    logic       busy16, done16, rd_en16, wr_en16;
    logic [3:0] rd_a16, rd_b16, wr_a16, wr_b16;
    logic [2:0] tw16;
    logic [1:0] stage16;

    int vectors = 0;
    int miscompares = 0;

    // Expected N=8 schedule indexed by cycle (0 = idle before start, 17/18 = idle after)
    int E_RD   [0:18] = '{0, 1,1,1,1, 0, 1,1,1,1, 0, 1,1,1,1, 0, 0, 0,0};
    int E_A    [0:18] = '{0, 0,2,4,6, 0, 0,1,4,5, 0, 0,1,2,3, 0, 0, 0,0};
    int E_B    [0:18] = '{0, 1,3,5,7, 0, 2,3,6,7, 0, 4,5,6,7, 0, 0, 0,0};
    int E_T    [0:18] = '{0, 0,0,0,0, 0, 0,2,0,2, 0, 0,1,2,3, 0, 0, 0,0};
    int E_STG  [0:18] = '{0, 0,0,0,0, 0, 1,1,1,1, 1, 2,2,2,2, 2, 2, 0,0};
    int E_BUSY [0:18] = '{0, 1,1,1,1, 1, 1,1,1,1, 1, 1,1,1,1, 1, 1, 0,0};
    int E_DONE [0:18] = '{0, 0,0,0,0, 0, 0,0,0,0, 0, 0,0,0,0, 0, 1, 0,0};

    // Twiddle W^k = cos - j*sin (2*pi*k/8), Q14
    int TWC [0:3] = '{16384, 11585, 0, -11585};
    int TWS [0:3] = '{0, -11585, -16384, -11585};

    int mem_re [0:7];
    int mem_im [0:7];
    int ra_re, ra_im, rb_re, rb_im;
    logic [1:0] tw_q;
    int wb_re, wb_im;

    fft_stage_sequencer #(.LOG2N(3)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
        .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_tw_addr(tw),
        .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b),
        .o_stage(stage)
    );

    fft_stage_sequencer #(.LOG2N(4)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start16),
        .o_busy(busy16), .o_done(done16), .o_rd_en(rd_en16),
        .o_rd_addr_a(rd_a16), .o_rd_addr_b(rd_b16), .o_tw_addr(tw16),
        .o_wr_en(wr_en16), .o_wr_addr_a(wr_a16), .o_wr_addr_b(wr_b16),
        .o_stage(stage16)
    );

    always #5 clk = ~clk;

    // Sample RAM (1-cycle synchronous read) with the butterfly on its registered output
    assign wb_re = (rb_re * TWC[tw_q] - rb_im * TWS[tw_q]) >>> 14;
    assign wb_im = (rb_re * TWS[tw_q] + rb_im * TWC[tw_q]) >>> 14;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= (i == 0) ? 1000 : 0;
                mem_im[i] <= 0;
            end
        end else begin
            if (rd_en) begin
                ra_re <= mem_re[rd_a];
                ra_im <= mem_im[rd_a];
                rb_re <= mem_re[rd_b];
                rb_im <= mem_im[rd_b];
                tw_q  <= tw;
            end
            if (wr_en) begin
                mem_re[wr_a] <= ra_re + wb_re;
                mem_im[wr_a] <= ra_im + wb_im;
                mem_re[wr_b] <= ra_re - wb_re;
                mem_im[wr_b] <= ra_im - wb_im;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero8(input string tag);
        chk({tag, " rd_en"}, 32'(rd_en), 0);
        chk({tag, " rd_a"},  32'(rd_a), 0);
        chk({tag, " rd_b"},  32'(rd_b), 0);
        chk({tag, " tw"},    32'(tw), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " wr_a"},  32'(wr_a), 0);
        chk({tag, " wr_b"},  32'(wr_b), 0);
        chk({tag, " busy"},  32'(busy), 0);
        chk({tag, " done"},  32'(done), 0);
        chk({tag, " stage"}, 32'(stage), 0);
    endtask

    task automatic chk_cycle(input string run, input int c);
        string t;
        t = $sformatf("%s c%0d", run, c);
        chk({t, " rd_en"}, 32'(rd_en), E_RD[c]);
        chk({t, " rd_a"},  32'(rd_a),  E_A[c]);
        chk({t, " rd_b"},  32'(rd_b),  E_B[c]);
        chk({t, " tw"},    32'(tw),    E_T[c]);
        chk({t, " wr_en"}, 32'(wr_en), E_RD[c-1]);
        chk({t, " wr_a"},  32'(wr_a),  E_A[c-1]);
        chk({t, " wr_b"},  32'(wr_b),  E_B[c-1]);
        chk({t, " busy"},  32'(busy),  E_BUSY[c]);
        chk({t, " done"},  32'(done),  E_DONE[c]);
        if (c <= 16) chk({t, " stage"}, 32'(stage), E_STG[c]);
    endtask

    // Start accepted at edge 0; cycles 1..18 checked against the tables.
    // With inject set, i_start is also raised in cycles 3, 7 (READ) and 16 (DONE).
    task automatic run_seq(input string run, input bit inject);
        start = 1'b1;
        tick();
        for (int c = 1; c <= 18; c++) begin
            chk_cycle(run, c);
            start = inject && (c == 3 || c == 7 || c == 16);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int done_cycle;
        int done_cnt;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk_zero8("async reset");
        tick();
        tick();
        chk_zero8("reset held");
        chk("reset busy16", 32'(busy16), 0);
        chk("reset wr_en16", 32'(wr_en16), 0);
        rst_n = 1'b1;

        // No activity without a fresh start
        tick();
        tick();
        chk_zero8("idle after reset");

        // Impulse preload, then a clean run checked cycle by cycle
        load = 1'b1;
        tick();
        load = 1'b0;
        run_seq("run", 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("impulse re[%0d]", i), 32'(mem_re[i]), 1000);
            chk($sformatf("impulse im[%0d]", i), 32'(mem_im[i]), 0);
        end

        // Spurious starts during READ and DONE must not disturb the schedule
        run_seq("inject", 1'b1);
        tick();
        chk("inject idle busy", 32'(busy), 0);
        chk("inject idle done", 32'(done), 0);

        // Reset in the middle of stage 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("pre-reset stage", 32'(stage), 1);
        chk("pre-reset rd_en", 32'(rd_en), 1);
        rst_n = 1'b0;
        #1;
        chk_zero8("mid reset");
        tick();
        chk_zero8("mid reset held");
        rst_n = 1'b1;
        tick();
        tick();
        chk_zero8("post reset idle");
        run_seq("restart", 1'b0);

        // N=16: final pair and completion cycle
        done_cycle = -1;
        done_cnt = 0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 35) begin
                chk("n16 last rd_a", 32'(rd_a16), 7);
                chk("n16 last rd_b", 32'(rd_b16), 15);
                chk("n16 last tw", 32'(tw16), 7);
                chk("n16 last stage", 32'(stage16), 3);
                chk("n16 last rd_en", 32'(rd_en16), 1);
            end
            if (done16) begin
                if (done_cycle < 0) done_cycle = c;
                done_cnt++;
            end
            tick();
        end
        chk("n16 done cycle", 32'(done_cycle), 37);
        chk("n16 done count", 32'(done_cnt), 1);
        chk("n16 busy end", 32'(busy16), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
